// File: rtl/bram_read_resp_buffer_pkg.sv
// Shared definitions for the BRAM read-response buffer.
//   defaultBufDepth : response FIFO depth giving full throughput with a
//                     registered-only reqReady.
//   creditWidth()   : width of the occupancy + inFlight credit sum.
package bram_read_resp_buffer_pkg;

  localparam int defaultBufDepth = 4;

  // The credit sum never exceeds depth. One bit beyond the occupancy width
  // is still kept so the compare is correct for any register value.
  function automatic int creditWidth(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/bram_read_resp_buffer_resp_fifo.sv
// Register-based circular FIFO holding captured RAM read data.
//   CLK, RST  : clock, synchronous active-high reset (pointers/occupancy only)
//   enq       : write enqData at the tail this cycle
//   deq       : pop the head this cycle (ignored while empty)
//   head      : data at the head of the FIFO (don't-care while empty)
//   occupancy : number of stored entries, 0..depth
//   notEmpty  : occupancy != 0
// depth must be a power of two and at least 2, so pointers wrap naturally.
module bram_read_resp_buffer_resp_fifo #(
  parameter int dataSize = 32,
  parameter int depth    = 4,
  parameter int ptrSize  = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                enq,
  input  logic [dataSize-1:0] enqData,
  input  logic                deq,
  output logic [dataSize-1:0] head,
  output logic [ptrSize:0]    occupancy,
  output logic                notEmpty
);

  logic [dataSize-1:0] mem [depth];
  logic [ptrSize-1:0]  wrPtr;
  logic [ptrSize-1:0]  rdPtr;
  logic                doDeq;

  assign notEmpty = (occupancy != '0);
  assign doDeq    = deq && notEmpty;
  assign head     = mem[rdPtr];

  // NOTE: storage has no reset; only pointers and occupancy define validity,
  // so clearing the array would cost reset routing and buy nothing.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[wrPtr] <= enqData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (enq) begin
        wrPtr <= wrPtr + ptrSize'(1);
      end
      if (doDeq) begin
        rdPtr <= rdPtr + ptrSize'(1);
      end
      // Simultaneous enq and deq cancel and leave occupancy unchanged.
      occupancy <= occupancy + (ptrSize + 1)'(enq) - (ptrSize + 1)'(doDeq);
    end
  end

  // The upstream credit rule must never let a capture land in a full FIFO.
  overflowCheck: assert property (@(posedge CLK) disable iff (RST)
    !(enq && occupancy == (ptrSize + 1)'(depth)));

endmodule

// File: rtl/bram_read_resp_buffer.sv
// Adds back-pressure to the registered read port of the dual-port BRAM.
// Requests drive the RAM directly; the read data, valid for exactly one
// cycle, is captured into a small FIFO and offered on a valid/ready port.
//   CLK, RST        : clock, synchronous active-high reset
//   reqValid/Ready  : read request handshake, reqAddr is the read address
//   bramReadEnable  : to RAM readEnable (a request is accepted this cycle)
//   bramReadAddr    : to RAM readAddr
//   bramReadData    : from RAM readData, valid the cycle after a read
//   respValid/Ready : response handshake, respData is the FIFO head
module bram_read_resp_buffer
  import bram_read_resp_buffer_pkg::*;
#(
  parameter int dataSize = 32,
  parameter int addrSize = 9,
  parameter int bufDepth = defaultBufDepth,
  parameter int ptrSize  = $clog2(bufDepth)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                reqValid,
  input  logic [addrSize-1:0] reqAddr,
  output logic                reqReady,
  output logic                bramReadEnable,
  output logic [addrSize-1:0] bramReadAddr,
  input  logic [dataSize-1:0] bramReadData,
  output logic                respValid,
  output logic [dataSize-1:0] respData,
  input  logic                respReady
);

  localparam int creditBits = creditWidth(bufDepth);

  logic                  inFlight;
  logic [ptrSize:0]      occupancy;
  logic [creditBits-1:0] creditUsed;
  logic                  reqAccept;
  logic                  respDeq;

  // Every accepted request reserves a FIFO slot before its data returns.
  // Built from registers only, so reqReady never depends on respReady.
  assign creditUsed = creditBits'(occupancy) + creditBits'(inFlight);
  assign reqReady   = (creditUsed < creditBits'(bufDepth));
  assign reqAccept  = reqValid && reqReady;

  assign bramReadEnable = reqAccept;
  assign bramReadAddr   = reqAddr;

  assign respDeq = respValid && respReady;

  // NOTE: non-blocking assignment for every flop, so all registers sample
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inFlight <= 1'b0;
    end else begin
      inFlight <= reqAccept;
    end
  end

  // Clearing inFlight on reset also drops any RAM data returning in the
  // first cycle after reset.
  bram_read_resp_buffer_resp_fifo #(
    .dataSize(dataSize),
    .depth   (bufDepth),
    .ptrSize (ptrSize)
  ) respFifo (
    .CLK      (CLK),
    .RST      (RST),
    .enq      (inFlight),
    .enqData  (bramReadData),
    .deq      (respDeq),
    .head     (respData),
    .occupancy(occupancy),
    .notEmpty (respValid)
  );

endmodule

// File: tb/tb_bram_read_resp_buffer.sv
// Self-checking bench: registered-read RAM model, response scoreboard, and
// one task per scenario.
module tb_bram_read_resp_buffer;

  localparam int dataSize = 32;
  localparam int addrSize = 9;
  localparam int bufDepth = 4;

  logic                CLK = 1'b0;
  logic                RST;
  logic                reqValid;
  logic [addrSize-1:0] reqAddr;
  logic                reqReady;
  logic                bramReadEnable;
  logic [addrSize-1:0] bramReadAddr;
  logic [dataSize-1:0] bramReadData;
  logic                respValid;
  logic [dataSize-1:0] respData;
  logic                respReady;

  int passCount  = 0;
  int checkCount = 0;

  logic [dataSize-1:0] mem [1 << addrSize];
  logic [dataSize-1:0] expQ [$];
  logic [dataSize-1:0] expWord;

  bram_read_resp_buffer #(
    .dataSize(dataSize),
    .addrSize(addrSize),
    .bufDepth(bufDepth)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .reqValid      (reqValid),
    .reqAddr       (reqAddr),
    .reqReady      (reqReady),
    .bramReadEnable(bramReadEnable),
    .bramReadAddr  (bramReadAddr),
    .bramReadData  (bramReadData),
    .respValid     (respValid),
    .respData      (respData),
    .respReady     (respReady)
  );

  always #5 CLK = ~CLK;

  // Registered-read RAM: data appears the cycle after readEnable.
  always @(posedge CLK) begin
    if (bramReadEnable) bramReadData <= mem[bramReadAddr];
  end

  // Scoreboard: push on accepted request, pop and compare on dequeue.
  always @(negedge CLK) begin
    if (RST) begin
      expQ.delete();
    end else begin
      if (respValid && respReady) begin
        checkCount++;
        if (expQ.size() == 0) begin
          $display("FAIL resp_unexpected: got %h expected no response", respData);
        end else begin
          expWord = expQ.pop_front();
          if (respData !== expWord)
            $display("FAIL resp_order: got %h expected %h", respData, expWord);
          else
            passCount++;
        end
      end
      if (reqValid && reqReady) expQ.push_back(mem[reqAddr]);
    end
  end

  // Inputs change 2 time units after the rising edge; outputs are sampled
  // just after the falling edge.
  task automatic stepCycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic sample();
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; reqValid = 1'b0; reqAddr = '0; respReady = 1'b0;
    stepCycle();
    stepCycle();
    RST = 1'b0;
    sample();
    checkCount++;
    if (reqReady !== 1'b1) $display("FAIL reset_reqReady: got %b expected 1", reqReady);
    else passCount++;
    checkCount++;
    if (respValid !== 1'b0) $display("FAIL reset_respValid: got %b expected 0", respValid);
    else passCount++;
    checkCount++;
    if (bramReadEnable !== 1'b0) $display("FAIL reset_bramReadEnable: got %b expected 0", bramReadEnable);
    else passCount++;
    stepCycle();
  endtask

  task automatic test_single_read();
    reqValid = 1'b1; reqAddr = addrSize'(5); respReady = 1'b1;
    sample();
    checkCount++;
    if (bramReadEnable !== 1'b1) $display("FAIL single_enable: got %b expected 1", bramReadEnable);
    else passCount++;
    checkCount++;
    if (bramReadAddr !== addrSize'(5)) $display("FAIL single_addr: got %h expected 5", bramReadAddr);
    else passCount++;
    stepCycle();
    reqValid = 1'b0;
    sample();
    checkCount++;
    if (respValid !== 1'b0) $display("FAIL single_n1_valid: got %b expected 0", respValid);
    else passCount++;
    stepCycle();
    sample();
    checkCount++;
    if (respValid !== 1'b1) $display("FAIL single_n2_valid: got %b expected 1", respValid);
    else passCount++;
    checkCount++;
    if (respData !== 32'hDEADBEEF) $display("FAIL single_n2_data: got %h expected deadbeef", respData);
    else passCount++;
    stepCycle();
    sample();
    checkCount++;
    if (respValid !== 1'b0) $display("FAIL single_n3_valid: got %b expected 0", respValid);
    else passCount++;
    stepCycle();
  endtask

  task automatic test_back_pressure();
    int a = 0;
    int budget = 0;
    respReady = 1'b0;
    for (int c = 0; c < 7; c++) begin
      reqValid = 1'b1; reqAddr = addrSize'(a);
      sample();
      checkCount++;
      if (reqReady !== (c < 4)) $display("FAIL bp_reqReady_c%0d: got %b expected %b", c, reqReady, (c < 4));
      else passCount++;
      checkCount++;
      if (respValid !== (c >= 2)) $display("FAIL bp_respValid_c%0d: got %b expected %b", c, respValid, (c >= 2));
      else passCount++;
      if (c >= 2) begin
        checkCount++;
        if (respData !== 32'd100) $display("FAIL bp_stable_c%0d: got %0d expected 100", c, respData);
        else passCount++;
      end
      if (reqReady) a++;
      stepCycle();
    end
    checkCount++;
    if (a != 4) $display("FAIL bp_accepted_full: got %0d expected 4", a);
    else passCount++;
    respReady = 1'b1;
    while ((a < 6 || expQ.size() != 0 || respValid) && budget < 40) begin
      reqValid = (a < 6); reqAddr = addrSize'(a);
      sample();
      if (reqValid && reqReady) a++;
      budget++;
      stepCycle();
    end
    reqValid = 1'b0;
    checkCount++;
    if (a != 6 || budget >= 40) $display("FAIL bp_drain: got accepted %0d cycles %0d expected 6 within 40", a, budget);
    else passCount++;
  endtask

  task automatic test_streaming();
    respReady = 1'b1;
    for (int k = 0; k < 18; k++) begin
      reqValid = (k < 16); reqAddr = addrSize'(16 + k);
      sample();
      if (k < 16) begin
        checkCount++;
        if (reqReady !== 1'b1) $display("FAIL stream_reqReady_k%0d: got %b expected 1", k, reqReady);
        else passCount++;
      end
      checkCount++;
      if (respValid !== (k >= 2)) $display("FAIL stream_respValid_k%0d: got %b expected %b", k, respValid, (k >= 2));
      else passCount++;
      stepCycle();
    end
    reqValid = 1'b0;
    sample();
    checkCount++;
    if (expQ.size() != 0 || respValid !== 1'b0)
      $display("FAIL stream_drained: got %0d pending valid %b expected 0 pending valid 0", expQ.size(), respValid);
    else passCount++;
    stepCycle();
  endtask

  task automatic test_random();
    int issued = 0;
    int cycles = 0;
    while (issued < 200 && cycles < 3000) begin
      reqValid  = ($urandom_range(0, 3) != 0);
      reqAddr   = addrSize'($urandom_range(0, 511));
      respReady = ($urandom_range(0, 1) == 1);
      sample();
      if (reqValid && reqReady) issued++;
      cycles++;
      stepCycle();
    end
    reqValid = 1'b0; respReady = 1'b1;
    cycles = 0;
    while ((expQ.size() != 0 || respValid) && cycles < 20) begin
      sample();
      cycles++;
      stepCycle();
    end
    checkCount++;
    if (issued != 200) $display("FAIL random_issued: got %0d expected 200", issued);
    else passCount++;
    checkCount++;
    if (expQ.size() != 0 || respValid !== 1'b0)
      $display("FAIL random_drain: got %0d pending valid %b expected 0 pending valid 0", expQ.size(), respValid);
    else passCount++;
  endtask

  task automatic test_reset_midflight();
    respReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      reqValid = 1'b1; reqAddr = addrSize'(k);
      sample();
      checkCount++;
      if (reqReady !== 1'b1) $display("FAIL midrst_accept_%0d: got %b expected 1", k, reqReady);
      else passCount++;
      stepCycle();
    end
    // A read issued during reset returns data in the cycle after; it must be dropped.
    RST = 1'b1; reqValid = 1'b1; reqAddr = addrSize'(3);
    sample();
    stepCycle();
    RST = 1'b0; reqValid = 1'b0; respReady = 1'b1;
    sample();
    checkCount++;
    if (respValid !== 1'b0) $display("FAIL midrst_respValid: got %b expected 0", respValid);
    else passCount++;
    checkCount++;
    if (reqReady !== 1'b1) $display("FAIL midrst_reqReady: got %b expected 1", reqReady);
    else passCount++;
    stepCycle();
    for (int k = 0; k < 6; k++) begin
      sample();
      checkCount++;
      if (respValid !== 1'b0) $display("FAIL midrst_stale_%0d: got %b expected 0", k, respValid);
      else passCount++;
      stepCycle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << addrSize); i++) mem[i] = $urandom();
    for (int i = 0; i < 6; i++) mem[i] = 32'(i + 100);
    mem[5] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    for (int i = 0; i < 6; i++) mem[i] = 32'(i + 100);
    test_back_pressure();
    test_streaming();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bram_read_resp_buffer.md
Name: bram_read_resp_buffer

Overview:
- Downstream companion to the team's dual-port block RAM with registered read.
- Accepts read requests on a valid/ready interface and drives the RAM read port. Captures the RAM read data one cycle later into a small FIFO and presents it on a valid/ready response interface.
- Purpose: the RAM's read data is valid for only one cycle and has no stall. This block adds back-pressure so consumers can stall without losing data.
- Credit accounting guarantees the FIFO never overflows.

Parameters:
- dataSize, 32, width of RAM data word and response data.
- addrSize, 9, width of RAM read address.
- bufDepth, 4, response FIFO entries. Must be a power of two and at least 2. 4 gives full throughput with no combinational ready path.
- ptrSize, 2, log2(bufDepth).

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- reqValid  input  1  read request present.
- reqAddr  input  addrSize  read address.
- reqReady  output  1  block can accept a request this cycle.
- bramReadEnable  output  1  to RAM readEnable.
- bramReadAddr  output  addrSize  to RAM readAddr.
- bramReadData  input  dataSize  from RAM readData, valid one cycle after the read is issued.
- respValid  output  1  head of FIFO holds data.
- respData  output  dataSize  head-of-FIFO data.
- respReady  input  1  consumer takes the head this cycle.

Behaviour:
- Reset:
  - On a clock edge with RST=1: occupancy=0, inFlight=0, rdPtr=wrPtr=0.
  - Outputs after reset: respValid=0, reqReady=1, bramReadEnable=0.
  - FIFO contents are not reset; respData is don't-care while respValid=0.
- Reset mid-operation: in-flight reads and buffered responses are discarded. Any bramReadData arriving in the cycle after reset is ignored.
- Request acceptance: a request is accepted in a cycle where reqValid && reqReady.
- reqReady = (occupancy + inFlight) < bufDepth. It is computed from registers only, with no combinational dependency on respReady or reqValid.
- RAM drive (combinational):
  - bramReadAddr = reqAddr.
  - bramReadEnable = reqValid && reqReady.
- inFlight register (0/1): next value = 1 if a request is accepted this cycle, else 0.
- Capture: when inFlight=1, write bramReadData into fifo[wrPtr] at the clock edge ending that cycle, then wrPtr+1.
- Latency:
  - Request accepted in cycle N; RAM data on bramReadData in cycle N+1; captured at the end of N+1.
  - respValid=1 from cycle N+2. No bypass path.
- Dequeue: respValid && respReady pops the head at the clock edge (rdPtr+1).
- respValid = (occupancy != 0). respData = fifo[rdPtr].
- Occupancy: next = occupancy + capture − dequeue.
  - Simultaneous capture and dequeue leaves occupancy unchanged.
  - Capture while occupancy==bufDepth cannot occur, because of the credit rule. Verification asserts this.
- Wrap-around: pointers are ptrSize bits and wrap modulo bufDepth. occupancy is ptrSize+1 bits.
- Ordering: responses are delivered strictly in request order.
- Throughput: one request per cycle sustained while respReady=1 (bufDepth ≥ 3).
- Full: with respReady=0, exactly bufDepth requests are accepted, then reqReady=0 until a dequeue occurs.
- Empty: respValid=0 and respReady is ignored.
- Stability: respValid and respData must hold stable while respValid && !respReady.

Decomposition:
- Shared package: response-buffer default depth constant and the credit-count width helper.
- One natural sub-module: resp_fifo. It is a register-based circular FIFO with enq, deq, occupancy, and head outputs.
- The top level holds the inFlight register, the credit compare, and the RAM port wiring.
- The RAM itself is not instantiated here; it is connected at the parent level.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then 0 -> reqReady=1, respValid=0, bramReadEnable=0.
- Single read: RAM model preloaded with mem[5]=0xDEADBEEF; request addr 5 accepted in cycle N with respReady=1 -> respValid=1 with respData=0xDEADBEEF in cycle N+2 only; respValid=0 in cycle N+3.
- Back-pressure: respReady=0, 6 requests offered back-to-back (addrs 0..5, mem[i]=i+100) -> 4 accepted, reqReady=0 from the cycle after the 4th acceptance. Then respReady=1 -> 100,101,102,103 in order, then the remaining two requests are accepted.
- Streaming: 16 consecutive requests, respReady=1 -> one accepted per cycle, 16 in-order responses, no bubble after the first.
- Simultaneous capture/dequeue with wrap: random respReady (50%) over 200 requests -> scoreboard matches in order, no overflow assertion, pointers wrap several times.
- Reset mid-flight: 3 requests accepted with respReady=0, RST pulsed for 1 cycle -> respValid=0 next cycle, no stale data appears afterwards, reqReady=1.
